// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI streaming transmitter: FSM state encoding,
// default word/frame sizes, synchronizer depth and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DEF_WORD_BITS   = 16;
  localparam int DEF_FRAME_WORDS = 500;
  localparam int SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous level into the clk domain through a flop chain and
// produces one-clk rise/fall pulses from an extra edge-detect register.
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   din    in   asynchronous input level
//   level  out  synchronized level
//   rise   out  one-clk pulse on a synchronized 0->1 transition
//   fall   out  one-clk pulse on a synchronized 1->0 transition
// STAGES must be 2 or more. RESET_VAL is the idle level of the input, so that
// reset itself never creates an edge pulse.
// -----------------------------------------------------------------------------
module edge_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_stream_tx.sv
// -----------------------------------------------------------------------------
// spi_stream_tx
// SPI mode-0 slave transmitter streaming words from a show-ahead FIFO to the
// Raspberry Pi, MSB first. All logic runs on clk; sclk and SPI_cs are sampled
// through synchronizers.
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   sclk        in   SPI clock from master (asynchronous)
//   SPI_cs      in   SPI chip select, active low (asynchronous)
//   fifo_data   in   FIFO head word, valid while fifo_empty is low
//   fifo_empty  in   FIFO empty flag
//   fifo_rd     out  one-clk FIFO pop strobe
//   MISO        out  serial data to master
//   word_done   out  pulse when the master samples the last bit of a word
//   frame_done  out  pulse together with the FRAME_WORDS-th word_done
//   underrun    out  sticky: a word was loaded while the FIFO was empty
//   busy        out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module spi_stream_tx
  import spi_pkg::*;
#(
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 SPI_cs,
  input  logic [WORD_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  output logic                 MISO,
  output logic                 word_done,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 busy
);

  localparam int BIT_W  = cnt_width(WORD_BITS);
  localparam int WCNT_W = cnt_width(FRAME_WORDS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   shreg_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [WCNT_W-1:0]      word_cnt_q;
  logic                   word_end_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   armed_q;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SPI_cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // The cs synchronizer resets to "deasserted", so if the master holds cs low
  // across a reset the chain shows a phantom fall once it refills. Frames are
  // only accepted after the lines have been seen at their idle levels with
  // real (post-reset) samples, which keeps a reset mid-frame from popping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settle_q[SYNC_STAGES-1] && cs_level && !sclk_level)
        armed_q <= 1'b1;
    end
  end

  // cs rise has priority over everything, including a coincident sclk edge.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cs_fall && armed_q) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_SHIFT;
        ST_SHIFT: if (sclk_fall && word_end_q) state_d = ST_LOAD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Shift register loads in LOAD and shifts on sclk falls; the fall after the
  // last bit is consumed by the transition to LOAD instead of a shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q  <= '0;
      underrun <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (fifo_empty) begin
        shreg_q  <= '0;
        underrun <= 1'b1;
      end else begin
        shreg_q <= fifo_data;
      end
    end else if (state_q == ST_SHIFT && sclk_fall && !cs_rise && !word_end_q) begin
      shreg_q <= {shreg_q[WORD_BITS-2:0], 1'b0};
    end
  end

  // word_end_q remembers that the last bit has been sampled and the next
  // sclk fall must reload rather than shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      word_end_q <= 1'b0;
    end else if (cs_rise || state_q != ST_SHIFT) begin
      bit_cnt_q  <= '0;
      word_end_q <= 1'b0;
    end else if (sclk_rise) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_q  <= '0;
        word_end_q <= 1'b1;
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           word_cnt_q <= '0;
    else if (word_done) word_cnt_q <= frame_done ? '0 : word_cnt_q + 1'b1;
  end

  assign word_done  = (state_q == ST_SHIFT) && sclk_rise && !cs_rise && (bit_cnt_q == LAST_BIT);
  assign frame_done = word_done && (word_cnt_q == LAST_WORD);
  assign fifo_rd    = (state_q == ST_LOAD) && !fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign MISO       = busy & shreg_q[WORD_BITS-1];

endmodule

// File: tb/tb_spi_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_stream_tx
// Self-checking bench: acts as the SPI master and the sample FIFO, and
// predicts every word, pop, word/frame pulse and underrun from a queue model.
// -----------------------------------------------------------------------------
module tb_spi_stream_tx;

  localparam int WB = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          SPI_cs;
  logic [WB-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          MISO;
  logic          word_done;
  logic          frame_done;
  logic          underrun;
  logic          busy;

  spi_stream_tx #(.WORD_BITS(WB), .FRAME_WORDS(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .SPI_cs     (SPI_cs),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .MISO       (MISO),
    .word_done  (word_done),
    .frame_done (frame_done),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO: the initial block writes, the clocked block pops.
  logic [WB-1:0] fifo_mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr];

  int rd_count  = 0;
  int wd_count  = 0;
  int fd_count  = 0;
  int fd_orphan = 0;

  // Pulse counters observed on the DUT outputs.
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_ptr   <= rd_ptr + 8'd1;
      rd_count <= rd_count + 1;
    end
    if (word_done)                fd_orphan <= fd_orphan;
    if (word_done)                wd_count  <= wd_count + 1;
    if (frame_done)               fd_count  <= fd_count + 1;
    if (frame_done && !word_done) fd_orphan <= fd_orphan + 1;
  end

  // Reference model state.
  logic [WB-1:0] model_q [$];
  int   exp_rd      = 0;
  int   exp_wd      = 0;
  int   exp_fd      = 0;
  int   done_words  = 0;
  logic exp_underrun = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [WB-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    model_q.push_back(w);
  endtask

  // Each word start takes the FIFO head, or zeros with underrun if empty.
  task automatic start_word(output logic [WB-1:0] w);
    if (model_q.size() > 0) begin
      w = model_q.pop_front();
      exp_rd++;
    end else begin
      w = '0;
      exp_underrun = 1'b1;
    end
  endtask

  task automatic check_counts(input string tag);
    checkOutput({tag, "_fifo_rd"},    32'(rd_count), 32'(exp_rd));
    checkOutput({tag, "_word_done"},  32'(wd_count), 32'(exp_wd));
    checkOutput({tag, "_frame_done"}, 32'(fd_count), 32'(exp_fd));
    checkOutput({tag, "_underrun"},   32'(underrun), 32'(exp_underrun));
  endtask

  // One chip-select session of n_words; abort_rises>0 cuts the last word
  // short after that many sclk rises. The final sclk fall and the cs rise
  // happen together, so the DUT must not reload for a further word.
  task automatic applyStimulus(input int n_words, input int abort_rises);
    logic [WB-1:0] exp_word;
    logic [WB-1:0] got;
    int   rises;
    bit   last_word;
    SPI_cs = 1'b0;
    tick(4);
    start_word(exp_word);
    checkOutput("miso_first_bit", 32'(MISO), 32'(exp_word[WB-1]));
    checkOutput("busy_in_word", 32'(busy), 32'd1);
    tick(2);
    for (int w = 0; w < n_words; w++) begin
      last_word = (w == n_words - 1);
      if (w > 0) start_word(exp_word);
      got   = '0;
      rises = (last_word && abort_rises > 0) ? abort_rises : WB;
      for (int b = 0; b < rises; b++) begin
        got  = {got[WB-2:0], MISO};
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        if (last_word && b == rises - 1) SPI_cs = 1'b1;
        else tick(4);
      end
      if (rises == WB) begin
        checkOutput("word_bits", 32'(got), 32'(exp_word));
        exp_wd++;
        done_words++;
        if (done_words % FW == 0) exp_fd++;
      end else begin
        checkOutput("partial_bits", 32'(got), 32'(exp_word >> (WB - rises)));
      end
    end
    tick(4);
    checkOutput("busy_after_cs_rise", 32'(busy), 32'd0);
    checkOutput("miso_idle", 32'(MISO), 32'd0);
    check_counts("session");
    tick(4);
  endtask

  initial begin
    logic [WB-1:0] exp_word;
    logic [WB-1:0] got;
    int n;
    int fill;

    rst    = 1'b0;
    sclk   = 1'b0;
    SPI_cs = 1'b1;
    tick(5);
    checkOutput("reset_miso", 32'(MISO), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    tick(6);

    $display("[TB] single word A5C3");
    push_word(16'hA5C3);
    applyStimulus(1, 0);

    $display("[TB] back-to-back words");
    push_word(16'h0001);
    push_word(16'h8000);
    push_word(16'hFFFF);
    applyStimulus(3, 0);

    $display("[TB] abort after 7 rises, then fresh word");
    push_word(16'h1234);
    applyStimulus(1, 7);
    push_word(16'hBEEF);
    applyStimulus(1, 0);

    $display("[TB] frame boundary");
    for (int i = 0; i < 5; i++) push_word(WB'($urandom));
    applyStimulus(5, 0);

    $display("[TB] random full-FIFO sessions");
    for (int s = 0; s < 16; s++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) push_word(WB'($urandom));
      applyStimulus(n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, WB - 1) : 0);
    end

    $display("[TB] empty FIFO underrun");
    applyStimulus(1, 0);

    $display("[TB] random sessions with short FIFO");
    for (int s = 0; s < 8; s++) begin
      n    = $urandom_range(1, 3);
      fill = $urandom_range(0, n);
      for (int i = 0; i < fill; i++) push_word(WB'($urandom));
      applyStimulus(n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, WB - 1) : 0);
    end

    $display("[TB] reset at bit 9");
    push_word(WB'($urandom));
    SPI_cs = 1'b0;
    tick(4);
    start_word(exp_word);
    tick(2);
    got = '0;
    for (int b = 0; b < 9; b++) begin
      got  = {got[WB-2:0], MISO};
      sclk = 1'b1;
      tick(4);
      if (b < 8) begin
        sclk = 1'b0;
        tick(4);
      end
    end
    checkOutput("pre_reset_bits", 32'(got), 32'(exp_word >> (WB - 9)));
    rst = 1'b0;
    #1;
    checkOutput("rst_miso", 32'(MISO), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rst_word_done", 32'(word_done), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    exp_underrun = 1'b0;
    done_words   = 0;
    sclk = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(20);
    checkOutput("no_pop_after_reset", 32'(rd_count), 32'(exp_rd));
    checkOutput("idle_after_reset", 32'(busy), 32'd0);
    SPI_cs = 1'b1;
    tick(8);
    push_word(WB'($urandom));
    applyStimulus(1, 0);
    for (int i = 0; i < 3; i++) push_word(WB'($urandom));
    applyStimulus(3, 0);

    checkOutput("frame_done_without_word_done", 32'(fd_orphan), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
